instr_fetch_unit: RTL and testbench

//  Initiator side of program_memory_bus.CONSUMER_A. Walks a PC, issues word reads to program memory,

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// MEM_LATENCY must match the program memory read pipeline depth.
package fetch_pkg;

    // Cycles from a read request to its data_valid response.
    localparam int unsigned MEM_LATENCY = 2;

    // One buffered instruction: its byte address and the fetched word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // One outstanding request travelling alongside the memory pipeline.
    typedef struct packed {
        logic        valid;
        logic        epoch;
        logic [31:0] pc;
    } inflight_t;

    // Force a byte address onto a 4-byte word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular response buffer between the memory capture path and decode.
// Flush has priority over push and pop; DEPTH must be a power of two.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W:0]         count_q;

    // Entry storage: write at the tail on push (a flushed push is discarded).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: walks the PC, issues one word read per cycle
// under a credit limit, tags requests with an epoch so responses that were
// in flight across a redirect are squashed, and buffers live responses for
// decode. Optional macro FETCH_PERF_CNT_EN builds the perf counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [31:0] mem_addr_out,
    output logic        mem_read_req_out,
    input  logic [31:0] mem_instr_in,
    input  logic        mem_data_valid_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] perf_issued_out,
    output logic [31:0] perf_squashed_out
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       pc_q;
    logic              epoch_q;
    inflight_t         tracker_q [MEM_LATENCY];
    inflight_t         tail;
    logic [MEM_LATENCY-1:0] rst_blank_q;

    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      fifo_head;
    fetch_entry_t      push_data;
    logic              fifo_push;
    logic              fifo_pop;

    logic [CNT_W:0]    inflight_cnt;
    logic [CNT_W:0]    occupancy;
    logic              credit;
    logic              issue;
    logic              tail_hit;

    // Credit check: buffered plus outstanding entries must leave a free slot.
    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + (CNT_W+1)'(tracker_q[i].valid);
        end
        occupancy = (CNT_W+1)'(fifo_count) + inflight_cnt;
        credit    = occupancy < (CNT_W+1)'(FIFO_DEPTH);
        issue     = rst_in && !redirect_in && credit;
    end

    // Response capture: only a tracked, current-epoch response is buffered.
    always_comb begin
        tail      = tracker_q[MEM_LATENCY-1];
        tail_hit  = mem_data_valid_in && tail.valid;
        fifo_push = tail_hit && !redirect_in && (tail.epoch == epoch_q);
        push_data = '{pc: tail.pc, instr: mem_instr_in};
        fifo_pop  = valid_out && ready_in && !redirect_in;
    end

    // PC and epoch: redirect reloads the aligned target, issue advances by a word.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc_q    <= RESET_PC;
            epoch_q <= 1'b0;
        end else if (redirect_in) begin
            pc_q    <= align_word(redirect_pc_in);
            epoch_q <= ~epoch_q;
        end else if (issue) begin
            pc_q    <= pc_q + 32'd4;
        end
    end

    // In-flight tracker shifting in lockstep with the memory pipeline.
    // On redirect, surviving entries are re-stamped with the pre-toggle epoch,
    // so they stay stale even when consecutive redirects toggle the 1-bit epoch
    // back to an earlier value.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                tracker_q[i] <= '0;
            end
        end else begin
            tracker_q[0] <= '{valid: issue, epoch: epoch_q, pc: pc_q};
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                tracker_q[i] <= '{valid: tracker_q[i-1].valid,
                                  epoch: redirect_in ? epoch_q : tracker_q[i-1].epoch,
                                  pc:    tracker_q[i-1].pc};
            end
        end
    end

    // Post-reset window in which responses to pre-reset requests may still arrive.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rst_blank_q <= '1;
        end else begin
            rst_blank_q <= rst_blank_q >> 1;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .flush     (redirect_in),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign mem_read_req_out = issue;
    assign mem_addr_out     = pc_q;
    assign valid_out        = (fifo_count != '0);
    assign instr_out        = fifo_head.instr;
    assign pc_out           = fifo_head.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_squashed_q;
    logic        squash;

    assign squash = tail_hit && !fifo_push;

    // Free-running event counters, cleared only by reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            perf_issued_q   <= '0;
            perf_squashed_q <= '0;
        end else begin
            if (issue) begin
                perf_issued_q <= perf_issued_q + 32'd1;
            end
            if (squash) begin
                perf_squashed_q <= perf_squashed_q + 32'd1;
            end
        end
    end

    assign perf_issued_out   = perf_issued_q;
    assign perf_squashed_out = perf_squashed_q;
`else
    assign perf_issued_out   = '0;
    assign perf_squashed_out = '0;
`endif

    // A response must always line up with a tracked request.
    a_resp_tracked: assert property (@(posedge clk_in) disable iff (!rst_in)
        mem_data_valid_in |-> (tail.valid || (rst_blank_q != '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 2-cycle program memory model
// returning addr ^ 32'hA5A5_0000.
module tb_instr_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_addr_out;
    logic        mem_read_req_out;
    logic [31:0] mem_instr_in;
    logic        mem_data_valid_in;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = '0;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] perf_issued_out;
    logic [31:0] perf_squashed_out;

    int checks = 0;
    int passes = 0;
    int nreq;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .mem_addr_out      (mem_addr_out),
        .mem_read_req_out  (mem_read_req_out),
        .mem_instr_in      (mem_instr_in),
        .mem_data_valid_in (mem_data_valid_in),
        .redirect_in       (redirect_in),
        .redirect_pc_in    (redirect_pc_in),
        .valid_out         (valid_out),
        .ready_in          (ready_in),
        .instr_out         (instr_out),
        .pc_out            (pc_out),
        .perf_issued_out   (perf_issued_out),
        .perf_squashed_out (perf_squashed_out)
    );

    always #5 clk_in = ~clk_in;

    // Program memory: fixed two-stage pipeline, independent of DUT reset.
    logic        m_v0 = 1'b0, m_v1 = 1'b0;
    logic [31:0] m_a0 = '0,   m_a1 = '0;
    always @(posedge clk_in) begin
        m_v0 <= mem_read_req_out;
        m_a0 <= mem_addr_out;
        m_v1 <= m_v0;
        m_a1 <= m_a0;
    end
    assign mem_data_valid_in = m_v1;
    assign mem_instr_in      = m_a1 ^ 32'hA5A5_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to mid-cycle, drive redirect, settle before sampling.
    task automatic step(input logic redir, input logic [31:0] rpc);
        @(negedge clk_in);
        redirect_in    = redir;
        redirect_pc_in = rpc;
        #1;
    endtask

    initial begin
        #1 rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        #1;
        chk("rst_req",   {31'd0, mem_read_req_out}, 32'd0);
        chk("rst_addr",  mem_addr_out, 32'h0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc",    pc_out, 32'h0);
        chk("rst_pi",    perf_issued_out, 32'h0);
        chk("rst_ps",    perf_squashed_out, 32'h0);

        // Streaming with ready held high: cycle 0 is the release cycle.
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step(1'b0, 32'h0);
            chk("t1_req",  {31'd0, mem_read_req_out}, 32'd1);
            chk("t1_addr", mem_addr_out, 32'(4 * c));
            if (c >= 3) begin
                chk("t1_valid", {31'd0, valid_out}, 32'd1);
                chk("t1_pc",    pc_out, 32'(4 * (c - 3)));
                chk("t1_instr", instr_out, 32'(4 * (c - 3)) ^ 32'hA5A5_0000);
            end else begin
                chk("t1_fill", {31'd0, valid_out}, 32'd0);
            end
        end

        // Redirect in cycle 6 with requests from cycles 4 and 5 in flight.
        step(1'b1, 32'h0000_0103);
        chk("t3_req_r",   {31'd0, mem_read_req_out}, 32'd0);
        chk("t3_valid_r", {31'd0, valid_out}, 32'd1);
        chk("t3_pc_r",    pc_out, 32'h0000_000C);
        step(1'b0, 32'h0);                              // cycle 7
        chk("t3_req7",    {31'd0, mem_read_req_out}, 32'd1);
        chk("t3_addr7",   mem_addr_out, 32'h0000_0100);
        chk("t3_valid7",  {31'd0, valid_out}, 32'd0);
        step(1'b0, 32'h0);                              // cycle 8
        chk("t3_addr8",   mem_addr_out, 32'h0000_0104);
        chk("t3_valid8",  {31'd0, valid_out}, 32'd0);
        chk("t3_sq",      perf_squashed_out, PERF ? 32'd2 : 32'd0);
        chk("t3_iss",     perf_issued_out, PERF ? 32'd7 : 32'd0);
        step(1'b0, 32'h0);                              // cycle 9
        chk("t3_valid9",  {31'd0, valid_out}, 32'd0);
        step(1'b0, 32'h0);                              // cycle 10
        chk("t3_valid10", {31'd0, valid_out}, 32'd1);
        chk("t3_pc10",    pc_out, 32'h0000_0100);
        chk("t3_instr10", instr_out, 32'hA5A5_0100);
        step(1'b0, 32'h0);                              // cycle 11
        chk("t3_pc11",    pc_out, 32'h0000_0104);

        // Back-to-back redirects: only the 0x300 stream survives.
        step(1'b1, 32'h0000_0200);                      // cycle 12
        chk("t4_req12",   {31'd0, mem_read_req_out}, 32'd0);
        chk("t4_pc12",    pc_out, 32'h0000_0108);
        step(1'b1, 32'h0000_0300);                      // cycle 13
        chk("t4_req13",   {31'd0, mem_read_req_out}, 32'd0);
        chk("t4_valid13", {31'd0, valid_out}, 32'd0);
        step(1'b0, 32'h0);                              // cycle 14
        chk("t4_addr14",  mem_addr_out, 32'h0000_0300);
        chk("t4_valid14", {31'd0, valid_out}, 32'd0);
        step(1'b0, 32'h0);                              // cycle 15
        chk("t4_valid15", {31'd0, valid_out}, 32'd0);
        step(1'b0, 32'h0);                              // cycle 16
        chk("t4_valid16", {31'd0, valid_out}, 32'd0);
        step(1'b0, 32'h0);                              // cycle 17
        chk("t4_pc17",    pc_out, 32'h0000_0300);
        chk("t4_instr17", instr_out, 32'hA5A5_0300);
        step(1'b0, 32'h0);                              // cycle 18
        chk("t4_pc18",    pc_out, 32'h0000_0304);
        chk("t4_sq",      perf_squashed_out, PERF ? 32'd4 : 32'd0);

        // PC wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC);                      // cycle 19
        step(1'b0, 32'h0);                              // cycle 20
        chk("t5_addr20",  mem_addr_out, 32'hFFFF_FFFC);
        step(1'b0, 32'h0);                              // cycle 21
        chk("t5_addr21",  mem_addr_out, 32'h0000_0000);
        step(1'b0, 32'h0);                              // cycle 22
        chk("t5_valid22", {31'd0, valid_out}, 32'd0);
        step(1'b0, 32'h0);                              // cycle 23
        chk("t5_pc23",    pc_out, 32'hFFFF_FFFC);
        chk("t5_instr23", instr_out, 32'h5A5A_FFFC);
        step(1'b0, 32'h0);                              // cycle 24
        chk("t5_pc24",    pc_out, 32'h0000_0000);
        chk("t5_instr24", instr_out, 32'hA5A5_0000);
        step(1'b0, 32'h0);                              // cycle 25
        chk("t5_pc25",    pc_out, 32'h0000_0004);

        // One-cycle reset mid-stream; late responses must not appear.
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        chk("t6_valid_rst", {31'd0, valid_out}, 32'd0);
        chk("t6_req_rst",   {31'd0, mem_read_req_out}, 32'd0);
        chk("t6_addr_rst",  mem_addr_out, 32'h0);
        chk("t6_pc_rst",    pc_out, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("t6_req0",   {31'd0, mem_read_req_out}, 32'd1);
        chk("t6_addr0",  mem_addr_out, 32'h0);
        chk("t6_valid0", {31'd0, valid_out}, 32'd0);
        step(1'b0, 32'h0);
        chk("t6_valid1", {31'd0, valid_out}, 32'd0);
        chk("t6_addr1",  mem_addr_out, 32'h4);
        step(1'b0, 32'h0);
        chk("t6_valid2", {31'd0, valid_out}, 32'd0);
        step(1'b0, 32'h0);
        chk("t6_pc3",    pc_out, 32'h0);
        chk("t6_instr3", instr_out, 32'hA5A5_0000);
        step(1'b0, 32'h0);
        chk("t6_pc4",    pc_out, 32'h4);
        chk("t6_iss",    perf_issued_out, PERF ? 32'd4 : 32'd0);
        chk("t6_sq",     perf_squashed_out, 32'd0);

        // Backpressure from reset: exactly four requests fill the FIFO.
        @(negedge clk_in);
        rst_in   = 1'b0;
        ready_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        nreq = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step(1'b0, 32'h0);
            nreq += int'(mem_read_req_out);
            if (c < 4) chk("t2_addr", mem_addr_out, 32'(4 * c));
            else       chk("t2_stall", {31'd0, mem_read_req_out}, 32'd0);
            if (c >= 3) chk("t2_head", pc_out, 32'h0);
        end
        chk("t2_nreq",  32'(nreq), 32'd4);
        chk("t2_valid", {31'd0, valid_out}, 32'd1);
        chk("t2_instr", instr_out, 32'hA5A5_0000);
        ready_in = 1'b1;
        step(1'b0, 32'h0);
        chk("t2_pc8",   pc_out, 32'h4);
        chk("t2_req8",  {31'd0, mem_read_req_out}, 32'd1);
        chk("t2_addr8", mem_addr_out, 32'h10);
        step(1'b0, 32'h0);
        chk("t2_pc9",   pc_out, 32'h8);
        chk("t2_addr9", mem_addr_out, 32'h14);
        step(1'b0, 32'h0);
        chk("t2_pc10",  pc_out, 32'hC);
        step(1'b0, 32'h0);
        chk("t2_pc11",    pc_out, 32'h10);
        chk("t2_instr11", instr_out, 32'hA5A5_0010);
        chk("t2_valid11", {31'd0, valid_out}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
